// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, buffers fetched words in an
// in-order queue and hands {pc, inst} pairs to decode over valid/ready.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] LIMIT = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

  state_t         state, state_nxt;
  logic [31:0]    fetch_pc, fetch_pc_nxt;
  logic [CW-1:0]  count, count_nxt, wr_idx;
  logic [31:0]    pc_q      [DEPTH];
  logic [31:0]    inst_q    [DEPTH];
  logic [31:0]    pc_q_nxt  [DEPTH];
  logic [31:0]    inst_q_nxt[DEPTH];
  logic           legal, pop, push;

  assign imem_addr   = fetch_pc;
  assign out_valid   = (count != '0);
  assign out_pc      = pc_q[0];
  assign out_inst    = inst_q[0];
  assign fetch_fault = (state == FAULT);

  always_comb begin
    legal  = (fetch_pc[1:0] == 2'b00) && (fetch_pc < LIMIT);
    pop    = out_valid && out_ready;
    push   = (state == RUN) && !halt && !redirect_valid && legal &&
             ((count < CW'(DEPTH)) || pop);
    wr_idx = count - CW'(pop);
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    count_nxt    = count;
    if (redirect_valid) begin
      state_nxt    = halt ? HALTED : RUN;
      fetch_pc_nxt = redirect_pc;
      count_nxt    = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt)        state_nxt = HALTED;
          else if (!legal) state_nxt = FAULT;
        end
        HALTED:  if (!halt) state_nxt = RUN;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RUN;
      endcase
      count_nxt = count - CW'(pop) + CW'(push);
      if (push) fetch_pc_nxt = fetch_pc + 32'd4;
    end
  end

  // Slot 0 is the head; it only shifts when a valid successor exists, so the
  // head (and thus out_pc/out_inst) keeps its last value once the queue empties.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pc_q_nxt[i]   = pc_q[i];
      inst_q_nxt[i] = inst_q[i];
    end
    if (pop && !redirect_valid) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        if (CW'(i + 1) < count) begin
          pc_q_nxt[i]   = pc_q[i+1];
          inst_q_nxt[i] = inst_q[i+1];
        end
      end
    end
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          pc_q_nxt[i]   = fetch_pc;
          inst_q_nxt[i] = imem_inst;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      count    <= count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= pc_q_nxt[i];
        inst_q[i] <= inst_q_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: scoreboard of expected {pc, inst} handshakes
// plus point checks of reset, backpressure, redirect, fault and halt behaviour.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_inst, redirect_pc, out_inst, out_pc;
  logic        redirect_valid, halt, out_valid, out_ready, fetch_fault;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [31:0] exp_pc[$];
  logic [31:0] exp_inst[$];

  always #5 clk = ~clk;

  // Memory word k holds A000_0000 + k
  assign imem_inst = 32'hA000_0000 + {2'b00, imem_addr[31:2]};

  ifetch_ctrl #(.RESET_PC(32'h0), .DEPTH(2), .MEM_WORDS(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_pc.push_back(pc);
    exp_inst.push_back(32'hA000_0000 + (pc >> 2));
  endtask

  // Scores the handshake of the current cycle, then advances to #1 after the edge
  task automatic cycle();
    if (out_valid && out_ready) begin
      n_checks++;
      assert (exp_pc.size() != 0) else begin
        n_fails++;
        $error("FAIL unexpected_pop: observed pc %h expected no transfer", out_pc);
      end
      if (exp_pc.size() != 0) begin
        chk("pop_pc", out_pc, exp_pc.pop_front());
        chk("pop_inst", out_inst, exp_inst.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int unsigned stop_at, input int unsigned budget);
    int unsigned n = 0;
    while (exp_pc.size() > stop_at && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", exp_pc.size(), stop_at);
  endtask

  task automatic release_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; out_ready = 1'b1; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_addr", imem_addr, 0);

    // 1: full stream to the end of memory, then fault
    release_reset();
    chk("t1_first_idle", out_valid, 0);
    for (int unsigned k = 0; k < 64; k++) expect_pc(k * 4);
    drain(1, 100);
    chk("t1_last_pc", out_pc, 32'd252);
    chk("t1_addr_end", imem_addr, 32'd256);
    chk("t1_no_fault_yet", fetch_fault, 0);
    drain(0, 5);
    chk("t1_fault", fetch_fault, 1);
    chk("t1_empty", out_valid, 0);

    // 2: backpressure fills the queue, then back-to-back drain
    rst_n = 1'b0; out_ready = 1'b0;
    #1;
    chk("t2_rst_fault", fetch_fault, 0);
    release_reset();
    repeat (6) cycle();
    chk("t2_full_valid", out_valid, 1);
    chk("t2_head", out_pc, 0);
    chk("t2_addr_hold", imem_addr, 32'd8);
    for (int unsigned k = 0; k < 4; k++) expect_pc(k * 4);
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      chk("t2_b2b_valid", out_valid, 1);
      cycle();
    end
    chk("t2_drained", exp_pc.size(), 0);
    out_ready = 1'b0;

    // 3: redirect coincident with the 0x08 handshake
    rst_n = 1'b0;
    #1;
    out_ready = 1'b1;
    release_reset();
    expect_pc(0); expect_pc(4); expect_pc(8);
    drain(1, 10);
    chk("t3_head8", out_pc, 32'h08);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    chk("t3_flushed", out_valid, 0);
    chk("t3_addr", imem_addr, 32'h40);
    expect_pc(32'h40); expect_pc(32'h44);
    drain(0, 10);
    out_ready = 1'b0;

    // 4: misaligned redirect faults, a good redirect recovers
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    cycle();
    redirect_valid = 1'b0;
    chk("t4_flush", out_valid, 0);
    chk("t4_addr", imem_addr, 32'h42);
    chk("t4_fault_pending", fetch_fault, 0);
    cycle();
    chk("t4_fault", fetch_fault, 1);
    chk("t4_valid0", out_valid, 0);
    cycle();
    chk("t4_valid_stays0", out_valid, 0);
    chk("t4_addr_hold", imem_addr, 32'h42);
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    cycle();
    redirect_valid = 1'b0;
    chk("t4_fault_clear", fetch_fault, 0);
    expect_pc(32'h10); expect_pc(32'h14); expect_pc(32'h18);
    drain(0, 10);

    // 5: halt for 4 cycles mid-stream
    chk("t5_addr_pre", imem_addr, 32'h20);
    halt = 1'b1;
    expect_pc(32'h1C);
    repeat (4) begin
      cycle();
      chk("t5_addr_frozen", imem_addr, 32'h20);
      chk("t5_drained", out_valid, 0);
    end
    halt = 1'b0;
    expect_pc(32'h20); expect_pc(32'h24); expect_pc(32'h28);
    drain(0, 10);
    out_ready = 1'b0;

    // 6: asynchronous reset with a full queue
    repeat (3) cycle();
    chk("t6_full", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_addr", imem_addr, 0);
    chk("t6_async_pc", out_pc, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    release_reset();
    expect_pc(0); expect_pc(4); expect_pc(8);
    drain(0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
